// File: rtl/arbiter_pkg.sv
// Shared types for the registered arbiter.
package arbiter_pkg;

  // Per-cycle next-state decision of the arbiter.
  typedef enum logic [1:0] {
    DecIdle,
    DecHold,
    DecArb
  } arb_dec_e;

endpackage

// File: rtl/arbiter_priority_encoder.sv
// Priority encoder: picks the highest-priority set bit and reports it encoded and one-hot.
module arbiter_priority_encoder #(
  parameter int unsigned WIDTH             = 4,
  parameter bit          LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned EncW             = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_unencoded,
  output logic             o_valid,
  output logic [EncW-1:0]  o_encoded,
  output logic [WIDTH-1:0] o_unencoded
);

  always_comb begin
    o_valid   = 1'b0;
    o_encoded = '0;
    // Scan from lowest to highest priority so the last hit is the winner.
    for (int i = 0; i < WIDTH; i++) begin
      if (LSB_HIGH_PRIORITY) begin
        if (i_unencoded[WIDTH-1-i]) begin
          o_valid   = 1'b1;
          o_encoded = EncW'(WIDTH - 1 - i);
        end
      end else if (i_unencoded[i]) begin
        o_valid   = 1'b1;
        o_encoded = EncW'(i);
      end
    end
    o_unencoded = o_valid ? (WIDTH'(1) << o_encoded) : '0;
  end

endmodule

// File: rtl/arbiter.sv
// Registered N-port arbiter with fixed or round-robin priority, optional grant blocking
// and acknowledge- or request-based release.
module arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned PORTS                 = 4,
  parameter bit          ARB_TYPE_ROUND_ROBIN  = 1'b0,
  parameter bit          ARB_BLOCK             = 1'b0,
  parameter bit          ARB_BLOCK_ACK         = 1'b1,
  parameter bit          ARB_LSB_HIGH_PRIORITY = 1'b0,
  localparam int unsigned EncW                 = $clog2(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [EncW-1:0]  grant_encoded
);

  logic [PORTS-1:0] r_grant, w_grant_d;
  logic             r_grant_valid, w_grant_valid_d;
  logic [EncW-1:0]  r_grant_encoded, w_grant_encoded_d;
  logic [PORTS-1:0] r_mask, w_mask_d;

  logic             w_req_valid, w_mreq_valid;
  logic [EncW-1:0]  w_req_enc, w_mreq_enc, w_win_enc;
  logic [PORTS-1:0] w_req_oh, w_mreq_oh, w_win_oh;
  arb_dec_e         w_dec;

  arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_req (
    .i_unencoded (request),
    .o_valid     (w_req_valid),
    .o_encoded   (w_req_enc),
    .o_unencoded (w_req_oh)
  );

  arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_masked (
    .i_unencoded (request & r_mask),
    .o_valid     (w_mreq_valid),
    .o_encoded   (w_mreq_enc),
    .o_unencoded (w_mreq_oh)
  );

  always_comb begin
    w_grant_d         = r_grant;
    w_grant_valid_d   = r_grant_valid;
    w_grant_encoded_d = r_grant_encoded;
    w_mask_d          = r_mask;

    if (ARB_BLOCK && !ARB_BLOCK_ACK && (|(r_grant & request))) begin
      w_dec = DecHold;
    end else if (ARB_BLOCK && ARB_BLOCK_ACK && r_grant_valid && !(|(r_grant & acknowledge))) begin
      w_dec = DecHold;
    end else if (w_req_valid) begin
      w_dec = DecArb;
    end else begin
      w_dec = DecIdle;
    end

    // Masked set empty means wrap around to the full request set.
    if (ARB_TYPE_ROUND_ROBIN && w_mreq_valid) begin
      w_win_oh  = w_mreq_oh;
      w_win_enc = w_mreq_enc;
    end else begin
      w_win_oh  = w_req_oh;
      w_win_enc = w_req_enc;
    end

    unique case (w_dec)
      DecHold: begin
      end
      DecArb: begin
        w_grant_d         = w_win_oh;
        w_grant_valid_d   = 1'b1;
        w_grant_encoded_d = w_win_enc;
        if (ARB_LSB_HIGH_PRIORITY) begin
          w_mask_d = {PORTS{1'b1}} << (32'(w_win_enc) + 32'd1);
        end else begin
          w_mask_d = {PORTS{1'b1}} >> (PORTS - 32'(w_win_enc));
        end
      end
      DecIdle: begin
        w_grant_d         = '0;
        w_grant_valid_d   = 1'b0;
        w_grant_encoded_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant         <= '0;
      r_grant_valid   <= 1'b0;
      r_grant_encoded <= '0;
      r_mask          <= '0;
    end else begin
      r_grant         <= w_grant_d;
      r_grant_valid   <= w_grant_valid_d;
      r_grant_encoded <= w_grant_encoded_d;
      r_mask          <= w_mask_d;
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = r_grant_valid;
  assign grant_encoded = r_grant_encoded;

endmodule
